// File: rtl/paridade_pkg.sv
`default_nettype none
// ============================================================================
// Module  : paridade_pkg
// Purpose : Definitions shared by both ends of the 5-bit parity-protected
//           code link: the frame state type, frame geometry constants and
//           the parity function. Transmitter and receiver both call
//           calc_paridade, so the two sides always agree on the parity bit.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package paridade_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int DATA_BITS  = 5;
  localparam int FRAME_BITS = 8;

  // Even parity when odd=0: data plus parity bit hold an even number of ones.
  function automatic logic calc_paridade(input logic [4:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/paridade_tx_baud.sv
`default_nettype none
// ============================================================================
// Module  : paridade_tx_baud
// Purpose : Bit-time counter for the parity transmitter. Counts
//           0..CLKS_PER_BIT-1 and pulses bit_done on the final count.
// Ports   : clk      - clock
//           rst      - synchronous active-high reset
//           clear    - restart the count (asserted on every state change)
//           bit_done - high during the last cycle of a bit-time
// Revision: 1.0 - initial release
// ============================================================================
module paridade_tx_baud #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam logic [7:0] LAST_COUNT = 8'(CLKS_PER_BIT - 1);

  logic [7:0] count;

  // With CLKS_PER_BIT=1 the count stays 0 and bit_done is permanently high.
  assign bit_done = (count == LAST_COUNT);

  always_ff @(posedge clk) begin
    if (rst || clear || bit_done) begin
      count <= 8'd0;
    end else begin
      count <= count + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/paridade_tx.sv
`default_nettype none
// ============================================================================
// Module  : paridade_tx
// Purpose : Transmit side of the 5-bit parity code link. Accepts B1..B5 over
//           valid/ready, computes the parity bit and sends one frame:
//           start(0), B1..B5 (B1 first), parity, stop(1).
// Ports   : clk, rst          - clock, synchronous active-high reset
//           B1..B5            - code bits, B1 is the MSB
//           in_valid/in_ready - input handshake (in_ready high only in IDLE)
//           tx                - registered serial line, idles high
//           busy              - registered, high while a frame is in progress
//           bitparidade       - registered parity of the last accepted code
// Revision: 1.0 - initial release
// ============================================================================
module paridade_tx
  import paridade_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD_PARITY   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic B1,
  input  logic B2,
  input  logic B3,
  input  logic B4,
  input  logic B5,
  input  logic in_valid,
  output logic in_ready,
  output logic tx,
  output logic busy,
  output logic bitparidade
);

  localparam logic [2:0] LAST_INDEX = 3'(DATA_BITS - 1);

  state_t     state, state_n;
  logic [4:0] shreg, shreg_n;
  logic [2:0] index, index_n;
  logic       par_n;
  logic       tx_n;
  logic       busy_n;
  logic       bit_done;
  logic       baud_clear;

  assign in_ready = (state == IDLE);

  // Keep the counter parked at 0 while idle so the start bit gets a full
  // bit-time, and restart it whenever the state changes.
  assign baud_clear = (state_n != state) || (state == IDLE);

  paridade_tx_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (baud_clear),
    .bit_done(bit_done)
  );

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    index_n = index;
    par_n   = bitparidade;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          shreg_n = {B1, B2, B3, B4, B5};
          par_n   = calc_paridade({B1, B2, B3, B4, B5}, 1'(ODD_PARITY));
          state_n = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_n = DATA;
          index_n = 3'd0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shreg_n = {shreg[3:0], 1'b0};
          if (index == LAST_INDEX) begin
            index_n = 3'd0;
            state_n = PARITY;
          end else begin
            index_n = index + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_done) state_n = STOP;
      end
      STOP: begin
        if (bit_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // tx is registered, so it is derived from the upcoming state/data so the
    // line level lines up with the state it belongs to.
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[4];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= 5'd0;
      index       <= 3'd0;
      bitparidade <= 1'b0;
      tx          <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      index       <= index_n;
      bitparidade <= par_n;
      tx          <= tx_n;
      busy        <= busy_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_paridade_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_paridade_tx
// Purpose : Self-checking bench for paridade_tx. Four instances cover
//           N=4 even, N=4 odd, N=2 even and N=1 even parity.
// Revision: 1.0 - initial release
// ============================================================================
module tb_paridade_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a   [4];
  logic       valid_a [4];
  logic [4:0] code_a  [4];
  logic       ready_a [4];
  logic       tx_a    [4];
  logic       busy_a  [4];
  logic       par_a   [4];

  int checks   = 0;
  int failures = 0;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    paridade_tx #(
      .CLKS_PER_BIT((i < 2) ? 4 : ((i == 2) ? 2 : 1)),
      .ODD_PARITY  ((i == 1) ? 1 : 0)
    ) u_dut (
      .clk        (clk),
      .rst        (rst_a[i]),
      .B1         (code_a[i][4]),
      .B2         (code_a[i][3]),
      .B3         (code_a[i][2]),
      .B4         (code_a[i][1]),
      .B5         (code_a[i][0]),
      .in_valid   (valid_a[i]),
      .in_ready   (ready_a[i]),
      .tx         (tx_a[i]),
      .busy       (busy_a[i]),
      .bitparidade(par_a[i])
    );
  end

  function automatic int n_of(input int d);
    return (d < 2) ? 4 : ((d == 2) ? 2 : 1);
  endfunction

  function automatic int odd_of(input int d);
    return (d == 1) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input int d, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d t=%0t observed=%b expected=%b", tag, d, $time, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one code and checks every cycle of its frame against a model built
  // from the frame format: start 0, code MSB first, parity, stop 1.
  // hold     : keep in_valid high after accept, presenting next_code
  // rst_at   : cycle index (1-based, from accept) where reset is applied
  // pulse_at : cycle index where a 01010 in_valid pulse is injected
  task automatic run_frame(input int d, input logic [4:0] code, input bit hold,
                           input logic [4:0] next_code, input int rst_at,
                           input int pulse_at, output int acc_cyc);
    int   n;
    logic p;
    logic bits [8];
    n = n_of(d);
    p = logic'(($countones(code) + odd_of(d)) % 2 != 0);
    bits[0] = 1'b0;
    for (int k = 0; k < 5; k++) bits[k + 1] = code[4 - k];
    bits[6] = p;
    bits[7] = 1'b1;

    code_a[d]  = code;
    valid_a[d] = 1'b1;
    check("ready_before_accept", d, ready_a[d], 1'b1);
    step();
    acc_cyc = cyc;
    if (hold) code_a[d] = next_code;
    else begin
      valid_a[d] = 1'b0;
      code_a[d]  = 5'($urandom);
    end

    for (int j = 1; j <= 8 * n; j++) begin
      check("tx_frame", d, tx_a[d], bits[(j - 1) / n]);
      check("busy_frame", d, busy_a[d], 1'b1);
      check("ready_frame", d, ready_a[d], 1'b0);
      check("parity_bit", d, par_a[d], p);
      if (j == rst_at) begin
        rst_a[d]   = 1'b1;
        valid_a[d] = 1'b1;
        step();
        rst_a[d] = 1'b0;
        check("rst_tx", d, tx_a[d], 1'b1);
        check("rst_busy", d, busy_a[d], 1'b0);
        check("rst_ready", d, ready_a[d], 1'b1);
        valid_a[d] = 1'b0;
        return;
      end
      if (j == pulse_at) begin
        code_a[d]  = 5'b01010;
        valid_a[d] = 1'b1;
      end else if (pulse_at > 0 && j == pulse_at + 1) begin
        valid_a[d] = 1'b0;
      end
      step();
    end
    check("idle_tx", d, tx_a[d], 1'b1);
    check("idle_busy", d, busy_a[d], 1'b0);
    check("idle_ready", d, ready_a[d], 1'b1);
    check("parity_held", d, par_a[d], p);
  endtask

  initial begin
    int a0, a1, dummy;
    for (int d = 0; d < 4; d++) begin
      rst_a[d]   = 1'b1;
      valid_a[d] = 1'b0;
      code_a[d]  = 5'd0;
    end
    step();
    step();
    for (int d = 0; d < 4; d++) rst_a[d] = 1'b0;
    for (int d = 0; d < 4; d++) begin
      check("reset_tx", d, tx_a[d], 1'b1);
      check("reset_busy", d, busy_a[d], 1'b0);
      check("reset_ready", d, ready_a[d], 1'b1);
      check("reset_parity", d, par_a[d], 1'b0);
    end

    // Even parity, N=4, code 10110 -> parity 1.
    run_frame(0, 5'b10110, 1'b0, 5'd0, 0, 0, dummy);
    step();

    // Odd parity, code 00000 -> parity 1.
    run_frame(1, 5'b00000, 1'b0, 5'd0, 0, 0, dummy);
    step();

    // Back-to-back on N=2 with in_valid held high.
    run_frame(2, 5'b11111, 1'b1, 5'b00001, 0, 0, a0);
    run_frame(2, 5'b00001, 1'b0, 5'd0, 0, 0, a1);
    checks++;
    assert ((a1 - a0) == 17) else begin
      failures++;
      $error("FAIL back_to_back_spacing observed=%0d expected=17", a1 - a0);
    end
    step();

    // Busy-ignore: in_valid pulse with 01010 during DATA.
    run_frame(0, 5'b11001, 1'b0, 5'd0, 0, 10, dummy);
    step();

    // Reset during B3 (first cycle of bit 3), rst and in_valid together,
    // then a clean frame.
    run_frame(0, 5'b10101, 1'b0, 5'd0, 13, 0, dummy);
    run_frame(0, 5'b01101, 1'b0, 5'd0, 0, 0, dummy);
    step();

    // N=1, code 11001.
    run_frame(3, 5'b11001, 1'b0, 5'd0, 0, 0, dummy);
    step();

    // Randomized codes on every configuration.
    for (int r = 0; r < 4; r++) begin
      for (int d = 0; d < 4; d++) begin
        run_frame(d, 5'($urandom), 1'b0, 5'd0, 0, 0, dummy);
        repeat ($urandom_range(0, 2)) step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/paridade_tx.md
# paridade_tx

Transmit side of the 5-bit parity-protected code link. Accepts a 5-bit code B1..B5 over a valid/ready handshake, computes its parity bit, and serializes one frame on a single line: start, B1..B5, parity, stop. The far end recovers B1..B5 and `bitparidade`, runs the parity check, and drives the 7-segment decoder. One frame is in flight at a time; there is no internal queue.

## Interface
Parameters:
- `CLKS_PER_BIT`, 4: clock cycles per serial bit. Legal range is 1..255.
- `ODD_PARITY`, 0: 0 selects even parity, 1 selects odd parity.

Ports:
- `clk`  in  1  sole clock; every flop is updated on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `B1`..`B5`  in  1 each  code bits. B1 is the MSB and is sent first.
- `in_valid`  in  1  the code on B1..B5 is valid.
- `in_ready`  out  1  the block can accept a code. Combinational: high exactly when state is IDLE.
- `tx`  out  1  serial line. Registered. Idles high.
- `busy`  out  1  a frame is in progress. Registered. High in every state except IDLE.
- `bitparidade`  out  1  parity bit of the last accepted code. Registered and held until the next accept.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Accept happens when `in_valid && in_ready`. On accept:
  - B1..B5 latch into a 5-bit shift register.
  - `bitparidade` latches B1^B2^B3^B4^B5^ODD_PARITY.
  - State moves to START.
  - B1..B5 are don't-care after the accept cycle.
- Line level in each state:
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx` = current shift-register MSB.
  - PARITY: `tx`=`bitparidade`.
  - STOP: `tx`=1.
- Each non-IDLE state lasts `CLKS_PER_BIT` cycles, timed by the baud counter. The counter runs 0..CLKS_PER_BIT-1 and clears on every state change.
- DATA holds for 5 bit-times. A 3-bit index runs 0..4. The shift register shifts left at the end of each bit-time.
- Transition chain: START to DATA, DATA to PARITY after index 4, PARITY to STOP, STOP to IDLE.
- Parity rule: with even parity, the five data bits plus the parity bit together hold an even number of ones. Odd parity inverts the bit.
- While busy:
  - `in_valid` is ignored.
  - No code is captured and nothing is dropped silently; the upstream block keeps `in_valid` asserted until it sees `in_ready`.
- Reset values: state IDLE, `tx`=1, `busy`=0, `bitparidade`=0, counters 0, shift register 0, `in_ready`=1.
- Reset mid-frame:
  - The frame is abandoned. In the cycle after `rst` is sampled high, `tx` is 1 and the state is IDLE.
  - No partial stop bit is sent.
  - If `rst` and `in_valid` are high together, reset wins and nothing is accepted.

## Timing
- Accept in cycle t:
  - `tx` falls at t+1.
  - The start bit covers cycles t+1..t+N, where N = `CLKS_PER_BIT`.
  - B1 covers t+N+1..t+2N, and so on through B5.
  - Parity covers t+6N+1..t+7N.
  - Stop covers t+7N+1..t+8N.
  - State is IDLE at t+8N+1.
- Frame length is 8N cycles. Minimum accept-to-accept spacing is 8N+1 cycles, with a single idle-high cycle between back-to-back frames.
- `busy` rises at t+1 and falls at t+8N+1. `in_ready` is low over exactly the same span.
- `bitparidade` is valid from t+1.
- With N=1 the counter is degenerate: every state lasts exactly 1 cycle.

## Structure
- Shared package `paridade_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - `DATA_BITS`=5 and `FRAME_BITS`=8;
  - the function `calc_paridade(data[4:0], odd)`.
- The receive-side checker uses the same package function, so both ends agree on parity by construction.
- Sub-module `paridade_tx_baud`: the baud counter. Inputs are `clk`, `rst`, and `clear` on state change. Output is a `bit_done` pulse on count N-1.
- The FSM, shift register and output flops live in the top module.

## Test plan
- Even parity, N=4, code B1..B5=1,0,1,1,0. Expect `bitparidade`=1. Expect `tx` = 0,1,0,1,1,0,1,1, each held 4 cycles, starting 1 cycle after accept. Expect `busy` high for 32 cycles.
- `ODD_PARITY`=1, code 0,0,0,0,0. Expect `bitparidade`=1. Expect the frame 0,0,0,0,0,0,1,1.
- Back-to-back, N=2, `in_valid` held high with codes 11111 then 00001. Expect the second accept exactly 17 cycles after the first. Expect one idle-high cycle between frames. Expect even parity bits 1 then 1.
- Busy-ignore: pulse `in_valid` with 01010 mid-frame. Expect no capture, an unchanged frame, and unchanged `bitparidade`.
- Reset mid-DATA, N=4: assert `rst` 1 cycle at bit B3. Expect `tx`=1, `busy`=0, `in_ready`=1 on the next cycle. Expect a new accept to produce a clean full frame.
- N=1, code 1,1,0,0,1. Expect an 8-cycle frame 0,1,1,0,0,1,1,1 and `busy` high for exactly 8 cycles.
